// File: rtl/ysyx_25010008_axi_pkg.sv
// Shared AXI4-Lite response codes and FSM encodings for the SRAM responder.
// Pure declarations: no logic, no latency, no backpressure.
// Imported by the responder top and by anything decoding its responses.
package ysyx_25010008_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    function automatic logic [1:0] resp_for(input logic hit);
        return hit ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/ysyx_25010008_sram_array.sv
// Word-organised SRAM: one byte-strobed synchronous write port, one combinational read port.
// Write lands on the clock edge; read reflects current contents with zero latency.
// No flow control; contents are deliberately not reset.
module ysyx_25010008_sram_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic [IDX_W-1:0]  ridx,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_25010008_axi_sram_slave.sv
// AXI4-Lite responder over on-chip SRAM, single address window, DECERR outside it.
// Latency: rvalid RD_LATENCY cycles after AR handshake, bvalid WR_LATENCY cycles after last AW/W handshake.
// Backpressure: one outstanding read and one write; responses held stable until rready/bready.
module ysyx_25010008_axi_sram_slave
    import ysyx_25010008_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 1,
    parameter int          WR_LATENCY  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);
    localparam logic [32:0]      WINDOW_BYTES = 33'(DEPTH_WORDS * 4);

    rd_state_t        rd_state, rd_next;
    logic [CNT_W-1:0] rd_cnt;
    logic [31:0]      rd_addr, rd_off, sram_rdata;
    logic             rd_hit;

    wr_state_t        wr_state, wr_next;
    logic [CNT_W-1:0] wr_cnt;
    logic [31:0]      wr_addr, wr_off, wr_data;
    logic [3:0]       wr_strb;
    logic             wr_hit, aw_held, w_held, aw_fire, w_fire, aw_done, w_done, sram_we;

    // Subtract-then-compare also rejects addresses below the base, since they wrap high.
    assign rd_off = rd_addr - ADDR_BASE;
    assign rd_hit = {1'b0, rd_off} < WINDOW_BYTES;
    assign wr_off = wr_addr - ADDR_BASE;
    assign wr_hit = {1'b0, wr_off} < WINDOW_BYTES;

    assign arready = (rd_state == R_IDLE);
    assign rvalid  = (rd_state == R_RESP);

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            R_IDLE:  if (arvalid)         rd_next = R_WAIT;
            R_WAIT:  if (rd_cnt == '0)    rd_next = R_RESP;
            R_RESP:  if (rready)          rd_next = R_IDLE;
            default:                      rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            rd_cnt  <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                R_IDLE: if (arvalid) begin
                    rd_addr <= araddr;
                    rd_cnt  <= RD_LOAD;
                end
                R_WAIT: if (rd_cnt == '0) begin
                    rdata <= rd_hit ? sram_rdata : 32'h0;
                    rresp <= resp_for(rd_hit);
                end else begin
                    rd_cnt <= rd_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign awready = (wr_state == W_IDLE) && !aw_held;
    assign wready  = (wr_state == W_IDLE) && !w_held;
    assign bvalid  = (wr_state == W_RESP);
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign aw_done = aw_held || aw_fire;
    assign w_done  = w_held || w_fire;

    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            W_IDLE:  if (aw_done && w_done) wr_next = W_WAIT;
            W_WAIT:  if (wr_cnt == '0)      wr_next = W_RESP;
            W_RESP:  if (bready)            wr_next = W_IDLE;
            default:                        wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            wr_cnt  <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                wr_addr <= awaddr;
                aw_held <= 1'b1;
            end
            if (w_fire) begin
                wr_data <= wdata;
                wr_strb <= wstrb;
                w_held  <= 1'b1;
            end
            // The held flags only matter in W_IDLE; clear them as we leave it.
            unique case (wr_state)
                W_IDLE: if (aw_done && w_done) begin
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                    wr_cnt  <= WR_LOAD;
                end
                W_WAIT: if (wr_cnt == '0) begin
                    bresp <= resp_for(wr_hit);
                end else begin
                    wr_cnt <= wr_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sram_we = (wr_state == W_WAIT) && (wr_cnt == '0) && wr_hit;

    ysyx_25010008_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clock (clock),
        .we    (sram_we),
        .widx  (wr_off[IDX_W+1:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .ridx  (rd_off[IDX_W+1:2]),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_ysyx_25010008_axi_sram_slave.sv
// Directed bench with response scoreboards; a second instance with RD_LATENCY=4 covers read backpressure.
module tb_ysyx_25010008_axi_sram_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 0, rready = 1, awvalid = 0, wvalid = 0, bready = 1;
    logic [3:0]  wstrb = '0;
    logic        ar4valid = 0, r4ready = 1;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        arready4, rvalid4, awready4, wready4, bvalid4;
    logic [31:0] rdata4;
    logic [1:0]  rresp4, bresp4;

    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    rexp_t      rq[$];
    logic [1:0] bq[$];
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    ysyx_25010008_axi_sram_slave dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    ysyx_25010008_axi_sram_slave #(.RD_LATENCY(4)) dut4 (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(ar4valid), .arready(arready4),
        .rdata(rdata4), .rresp(rresp4), .rvalid(rvalid4), .rready(r4ready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready4),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready4),
        .bresp(bresp4), .bvalid(bvalid4), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_r(input string tag, input int exp_lat);
        int    n = 0;
        rexp_t e;
        while (rvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_rlat"}, 32'(n), 32'(exp_lat));
        e = rq.pop_front();
        chk({tag, "_rdata"}, rdata, e.data);
        chk({tag, "_rresp"}, {30'h0, rresp}, {30'h0, e.resp});
        step();
        chk({tag, "_rdone"}, {30'h0, rvalid, arready}, 32'h1);
    endtask

    task automatic wait_b(input string tag, input int exp_lat);
        int         n = 0;
        logic [1:0] e;
        while (bvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_blat"}, 32'(n), 32'(exp_lat));
        e = bq.pop_front();
        chk({tag, "_bresp"}, {30'h0, bresp}, {30'h0, e});
        chk({tag, "_b4"}, {29'h0, bvalid4, bresp4}, {29'h0, 1'b1, e});
        step();
        chk({tag, "_bdone"}, {28'h0, bvalid, awready, wready, awready4 & wready4}, 32'h7);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        rq.push_back('{exp_data, exp_resp});
        araddr  = addr;
        arvalid = 1;
        step();
        arvalid = 0;
        wait_r(tag, 1);
    endtask

    // mode 0: AW and W together; 1: AW then W next cycle; 2: W two cycles before AW
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input logic [1:0] exp_resp);
        bq.push_back(exp_resp);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        case (mode)
            0: begin
                awvalid = 1; wvalid = 1; step(); awvalid = 0; wvalid = 0;
            end
            1: begin
                awvalid = 1; step(); awvalid = 0;
                wvalid  = 1; step(); wvalid  = 0;
            end
            default: begin
                wvalid = 1; step(); wvalid = 0;
                chk({tag, "_wheld"}, {29'h0, bvalid, awready, wready}, 32'h2);
                step();
                chk({tag, "_noearlyb"}, {31'h0, bvalid}, 32'h0);
                awvalid = 1; step(); awvalid = 0;
            end
        endcase
        wait_b(tag, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rexp_t e4;
        int    n;

        #1;
        chk("rst_ctl", {27'h0, arready, awready, wready, rvalid, bvalid}, 32'h1C);
        chk("rst_dat", rdata, 32'h0);
        chk("rst_resp", {28'h0, rresp, bresp}, 32'h0);
        repeat (3) step();
        reset = 0;

        axi_write("wr_beef", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
        axi_read ("rd_beef", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // RD_LATENCY=4 instance with rready low across rvalid
        rq.push_back('{32'hDEAD_BEEF, 2'b00});
        araddr = 32'h8000_0010; r4ready = 0; ar4valid = 1;
        step();
        ar4valid = 0;
        chk("bp_arready_low", {31'h0, arready4}, 32'h0);
        n = 0;
        while (rvalid4 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("bp_lat4", 32'(n), 32'd4);
        e4 = rq.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_data", rdata4, e4.data);
            chk("bp_hold_ctl", {29'h0, rvalid4, rresp4}, {29'h0, 1'b1, e4.resp});
            step();
        end
        r4ready = 1;
        step();
        chk("bp_done", {30'h0, rvalid4, arready4}, 32'h1);

        axi_write("wr_word", 32'h8000_0010, 32'h1122_3344, 4'hF, 0, 2'b00);
        axi_write("wr_byte", 32'h8000_0012, 32'h00AA_0000, 4'b0100, 1, 2'b00);
        axi_read ("rd_byte", 32'h8000_0010, 32'h11AA_3344, 2'b00);

        axi_write("w_first", 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2, 2'b00);
        axi_read ("rd_wfirst", 32'h8000_0000, 32'hCAFE_F00D, 2'b00);

        axi_read ("rd_oor", 32'h1000_0000, 32'h0, 2'b11);
        axi_write("wr_oor", 32'h1000_0000, 32'h1234_5678, 4'hF, 0, 2'b11);
        axi_read ("rd_after_oor", 32'h8000_0000, 32'hCAFE_F00D, 2'b00);

        axi_write("wr_last", 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 1, 2'b00);
        axi_read ("rd_last", 32'h8000_3FFF, 32'hA5A5_5A5A, 2'b00);
        axi_read ("rd_past_end", 32'h8000_4000, 32'h0, 2'b11);
        axi_read ("rd_below", 32'h7FFF_FFFC, 32'h0, 2'b11);
        axi_write("wr_past_end", 32'h8000_4000, 32'h0BAD_0BAD, 4'hF, 0, 2'b11);
        axi_write("wr_nostrb", 32'h8000_3FFC, 32'hFFFF_FFFF, 4'h0, 0, 2'b00);
        axi_read ("rd_nostrb", 32'h8000_3FFC, 32'hA5A5_5A5A, 2'b00);

        // reset while the write sits in W_WAIT
        awaddr = 32'h8000_0000; wdata = 32'h5555_5555; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        reset = 1;
        #1;
        chk("mid_rst_ctl", {27'h0, arready, awready, wready, rvalid, bvalid}, 32'h1C);
        chk("mid_rst_dat", rdata, 32'h0);
        chk("mid_rst_resp", {28'h0, rresp, bresp}, 32'h0);
        #1;
        reset = 0;
        step();
        chk("mid_rst_nob", {31'h0, bvalid}, 32'h0);
        axi_read ("rd_not_committed", 32'h8000_0000, 32'hCAFE_F00D, 2'b00);
        axi_write("wr_post_rst", 32'h8000_0004, 32'h0BAD_CAFE, 4'hF, 1, 2'b00);
        axi_read ("rd_post_rst", 32'h8000_0004, 32'h0BAD_CAFE, 2'b00);

        // read sample and write commit to the same word in the same cycle
        axi_write("wr_coll_init", 32'h8000_0008, 32'h0102_0304, 4'hF, 0, 2'b00);
        rq.push_back('{32'h0102_0304, 2'b00});
        bq.push_back(2'b00);
        bready = 0;
        araddr = 32'h8000_0008; awaddr = 32'h8000_0008;
        wdata = 32'hFFFF_0000; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        step();
        arvalid = 0; awvalid = 0; wvalid = 0;
        wait_r("coll", 1);
        bready = 1;
        wait_b("coll", 0);
        axi_read ("rd_coll_after", 32'h8000_0008, 32'hFFFF_0000, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
